// File: rtl/aluctrl_seq.sv
// Sequenced mMIPS ALU controller: decodes ALUop/funct/Shamt into ALUctrl codes,
// splitting shifts into native 8/2/1 steps and stretching multiply over MULT_CYCLES cycles.
module aluctrl_seq #(
    parameter int unsigned SHAMT_W     = 5,
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         ALUop,
    input  logic [5:0]         functionCode,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               kill,
    output logic [5:0]         ALUctrl,
    output logic               out_valid,
    output logic               out_first,
    output logic               out_last
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StMult
    } state_e;

    typedef enum logic [1:0] {
        KindSll,
        KindSrl,
        KindSra
    } shift_kind_e;

    localparam logic [3:0] MultLast = 4'(MULT_CYCLES);
    localparam logic [5:0] CtrlMult = 6'h13;

    state_e             state_q, state_d;
    shift_kind_e        kind_q, kind_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [5:0]         ctrl_q, ctrl_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;

    logic               accept;
    logic               is_shift;
    logic               is_mult;
    shift_kind_e        new_kind;
    shift_kind_e        step_kind;
    logic [SHAMT_W-1:0] step_src;
    logic [1:0]         step_sel;
    logic [SHAMT_W-1:0] step_nxt;

    function automatic logic [5:0] decode_single(input logic [4:0] op, input logic [5:0] fn);
        logic [5:0] code;
        code = 6'h00;
        case (op)
            5'd0: code = 6'h02;
            5'd1: code = 6'h06;
            5'd2: begin
                case (fn)
                    6'h20:   code = 6'h02;
                    6'h21:   code = 6'h03;
                    6'h23:   code = 6'h06;
                    6'h25:   code = 6'h01;
                    6'h26:   code = 6'h04;
                    6'h2A:   code = 6'h07;
                    6'h2B:   code = 6'h08;
                    6'h30:   code = 6'h30;
                    default: code = 6'h00;
                endcase
            end
            5'd3:    code = 6'h03;
            5'd5:    code = 6'h01;
            5'd6:    code = 6'h04;
            5'd7:    code = 6'h07;
            5'd8:    code = 6'h08;
            5'd9:    code = 6'h09;
            default: code = 6'h00;
        endcase
        return code;
    endfunction

    // Largest native step that fits: 2 -> 8, 1 -> 2, 0 -> 1.
    function automatic logic [1:0] pick_step(input logic [SHAMT_W-1:0] r);
        if (r >= SHAMT_W'(8)) begin
            return 2'd2;
        end else if (r >= SHAMT_W'(2)) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic [SHAMT_W-1:0] step_size(input logic [1:0] sel);
        case (sel)
            2'd2:    return SHAMT_W'(8);
            2'd1:    return SHAMT_W'(2);
            default: return SHAMT_W'(1);
        endcase
    endfunction

    function automatic logic [5:0] shift_code(input shift_kind_e kind, input logic [1:0] sel);
        logic [5:0] base;
        case (kind)
            KindSrl: base = 6'h0D;
            KindSra: base = 6'h10;
            default: base = 6'h0A;
        endcase
        return base + {4'b0000, sel};
    endfunction

    assign is_shift = (ALUop == 5'd2) &&
                      (functionCode == 6'h00 || functionCode == 6'h02 || functionCode == 6'h03);
    assign is_mult  = (ALUop == 5'd2) && (functionCode == 6'h19);

    always_comb begin
        case (functionCode)
            6'h02:   new_kind = KindSrl;
            6'h03:   new_kind = KindSra;
            default: new_kind = KindSll;
        endcase
    end

    // Ready while idle or while the current op presents its final step.
    assign in_ready = (state_q == StIdle || last_q) & ~kill & reset_n;
    assign accept   = in_valid & in_ready;

    assign step_src  = accept ? Shamt : rem_q;
    assign step_kind = accept ? new_kind : kind_q;
    assign step_sel  = pick_step(step_src);
    assign step_nxt  = step_src - step_size(step_sel);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ctrl_d  = 6'h00;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;

        if (kill) begin
            state_d = StIdle;
            rem_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = 1'b1;
            state_d = StIdle;
            rem_d   = '0;
            cnt_d   = '0;
            if (is_shift) begin
                kind_d = new_kind;
                // A zero shift is a single nop step.
                if (Shamt != '0) begin
                    ctrl_d = shift_code(step_kind, step_sel);
                    rem_d  = step_nxt;
                    last_d = (step_nxt == '0);
                    if (step_nxt != '0) begin
                        state_d = StShift;
                    end
                end
            end else if (is_mult) begin
                ctrl_d = CtrlMult;
                if (MULT_CYCLES > 1) begin
                    last_d  = 1'b0;
                    cnt_d   = 4'd1;
                    state_d = StMult;
                end
            end else begin
                ctrl_d = decode_single(ALUop, functionCode);
            end
        end else begin
            case (state_q)
                StShift: begin
                    if (rem_q != '0) begin
                        valid_d = 1'b1;
                        ctrl_d  = shift_code(step_kind, step_sel);
                        rem_d   = step_nxt;
                        last_d  = (step_nxt == '0);
                    end else begin
                        state_d = StIdle;
                    end
                end
                StMult: begin
                    if (cnt_q != MultLast) begin
                        valid_d = 1'b1;
                        ctrl_d  = CtrlMult;
                        cnt_d   = cnt_q + 4'd1;
                        last_d  = ((cnt_q + 4'd1) == MultLast);
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            kind_q  <= KindSll;
            rem_q   <= '0;
            cnt_q   <= '0;
            ctrl_q  <= 6'h00;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign ALUctrl   = ctrl_q;
    assign out_valid = valid_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_aluctrl_seq.sv
// Scoreboard bench for aluctrl_seq: three instances (5-bit shamt/4-cycle mult,
// 6-bit shamt, 1-cycle mult) driven with directed vectors and hand-computed steps.
module tb_aluctrl_seq;

    typedef struct packed {
        int         cyc;
        logic [5:0] ctrl;
        logic       f;
        logic       l;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst_n [3];
    logic       vld   [3];
    logic       kil   [3];
    logic [4:0] op    [3];
    logic [5:0] fn    [3];
    logic [4:0] sh0;
    logic [5:0] sh1;
    logic [4:0] sh2;
    logic       rdy   [3];
    logic [5:0] ctrl  [3];
    logic       ov    [3];
    logic       of    [3];
    logic       ol    [3];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    aluctrl_seq #(.SHAMT_W(5), .MULT_CYCLES(4)) u_dut (
        .clock(clock), .reset_n(rst_n[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .ALUop(op[0]), .functionCode(fn[0]), .Shamt(sh0), .kill(kil[0]),
        .ALUctrl(ctrl[0]), .out_valid(ov[0]), .out_first(of[0]), .out_last(ol[0])
    );

    aluctrl_seq #(.SHAMT_W(6), .MULT_CYCLES(4)) u_dut_w6 (
        .clock(clock), .reset_n(rst_n[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .ALUop(op[1]), .functionCode(fn[1]), .Shamt(sh1), .kill(kil[1]),
        .ALUctrl(ctrl[1]), .out_valid(ov[1]), .out_first(of[1]), .out_last(ol[1])
    );

    aluctrl_seq #(.SHAMT_W(5), .MULT_CYCLES(1)) u_dut_m1 (
        .clock(clock), .reset_n(rst_n[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .ALUop(op[2]), .functionCode(fn[2]), .Shamt(sh2), .kill(kil[2]),
        .ALUctrl(ctrl[2]), .out_valid(ov[2]), .out_first(of[2]), .out_last(ol[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit got);
        got = 1'b0;
        e   = '0;
        case (d)
            0:       if (q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
            1:       if (q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
    endtask

    // n steps of one code from cycle c; first flag on the first, last flag on the final one.
    task automatic exp_rep(input int d, input int c, input logic [5:0] code, input int n,
                           input bit f, input bit l);
        for (int i = 0; i < n; i++) begin
            push_exp(d, '{cyc: c + i, ctrl: code, f: f && (i == 0), l: l && (i == n - 1)});
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [4:0] o, input logic [5:0] f,
                         input logic [5:0] s);
        vld[d] = v;
        op[d]  = o;
        fn[d]  = f;
        case (d)
            0:       sh0 = s[4:0];
            1:       sh1 = s;
            default: sh2 = s[4:0];
        endcase
    endtask

    task automatic issue(input int d, input logic [4:0] o, input logic [5:0] f,
                         input logic [5:0] s);
        drive(d, 1'b1, o, f, s);
        #1;
        check($sformatf("in_ready at issue d%0d", d), 32'(rdy[d]), 32'd1);
    endtask

    // Monitor: pops one expectation per live step, checks idle outputs otherwise.
    always @(negedge clock) begin
        exp_t e;
        bit   got;
        for (int d = 0; d < 3; d++) begin
            if (ov[d] === 1'b1) begin
                pop_exp(d, e, got);
                checks++;
                if (!got) begin
                    errors++;
                    $display("FAIL unexpected step d%0d: got ctrl=%0h first=%0b last=%0b, expected no output (cycle %0d)",
                             d, ctrl[d], of[d], ol[d], cyc);
                end else if (ctrl[d] !== e.ctrl || of[d] !== e.f || ol[d] !== e.l || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL step d%0d: got ctrl=%0h first=%0b last=%0b cycle=%0d, expected ctrl=%0h first=%0b last=%0b cycle=%0d",
                             d, ctrl[d], of[d], ol[d], cyc, e.ctrl, e.f, e.l, e.cyc);
                end
            end else begin
                check($sformatf("idle outputs d%0d", d), {26'd0, ctrl[d], of[d], ol[d]}, 32'd0);
            end
        end
    end

    initial begin
        int e;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            kil[d]   = 1'b0;
            drive(d, 1'b0, 5'd0, 6'd0, 6'd0);
        end
        tick();
        tick();

        check("reset outputs", {26'd0, ctrl[0], ov[0], of[0], ol[0]} >> 0, 32'd0);
        check("in_ready in reset", 32'(rdy[0]), 32'd0);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        #1;
        check("in_ready after reset", 32'(rdy[0]), 32'd1);

        // Back-to-back single-step ops.
        e = cyc;
        issue(0, 5'd2, 6'h2A, 6'd0); exp_rep(0, e + 1, 6'h07, 1, 1, 1); tick();
        issue(0, 5'd9, 6'h00, 6'd0); exp_rep(0, e + 2, 6'h09, 1, 1, 1); tick();
        issue(0, 5'd2, 6'h30, 6'd0); exp_rep(0, e + 3, 6'h30, 1, 1, 1); tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();

        // SLL 13 = 8+2+2+1, with a pending op held until the last step.
        e = cyc;
        issue(0, 5'd2, 6'h00, 6'd13);
        exp_rep(0, e + 1, 6'h0C, 1, 1, 0);
        exp_rep(0, e + 2, 6'h0B, 2, 0, 0);
        exp_rep(0, e + 4, 6'h0A, 1, 0, 1);
        tick();
        drive(0, 1'b1, 5'd9, 6'h00, 6'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("in_ready mid-shift", 32'(rdy[0]), 32'd0);
            tick();
        end
        #1;
        check("in_ready on last step", 32'(rdy[0]), 32'd1);
        exp_rep(0, e + 5, 6'h09, 1, 1, 1);
        tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();

        // SRA 31 = 3x8 + 3x2 + 1.
        e = cyc;
        issue(0, 5'd2, 6'h03, 6'd31);
        exp_rep(0, e + 1, 6'h12, 3, 1, 0);
        exp_rep(0, e + 4, 6'h11, 3, 0, 0);
        exp_rep(0, e + 7, 6'h10, 1, 0, 1);
        tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        repeat (8) tick();

        // SRL 0 is a single nop step.
        e = cyc;
        issue(0, 5'd2, 6'h02, 6'd0); exp_rep(0, e + 1, 6'h00, 1, 1, 1); tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();

        // Multiply held for 4 cycles.
        e = cyc;
        issue(0, 5'd2, 6'h19, 6'd0); exp_rep(0, e + 1, 6'h13, 4, 1, 1); tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("in_ready mid-mult", 32'(rdy[0]), 32'd0);
            tick();
        end
        #1;
        check("in_ready last mult", 32'(rdy[0]), 32'd1);
        tick();

        // SLL 20 killed on its second step, with a competing in_valid.
        e = cyc;
        issue(0, 5'd2, 6'h00, 6'd20);
        exp_rep(0, e + 1, 6'h0C, 2, 1, 0);
        tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();
        drive(0, 1'b1, 5'd9, 6'h00, 6'd0);
        kil[0] = 1'b1;
        #1;
        check("in_ready under kill", 32'(rdy[0]), 32'd0);
        tick();
        kil[0] = 1'b0;
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        #1;
        check("out_valid after kill", 32'(ov[0]), 32'd0);
        check("ALUctrl after kill", 32'(ctrl[0]), 32'd0);
        check("in_ready after kill", 32'(rdy[0]), 32'd1);
        tick();

        // Reset for one cycle in the middle of a multiply.
        e = cyc;
        issue(0, 5'd2, 6'h19, 6'd0);
        exp_rep(0, e + 1, 6'h13, 1, 1, 0);
        exp_rep(0, e + 2, 6'h13, 1, 0, 0);
        tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();
        rst_n[0] = 1'b0;
        #1;
        check("in_ready during reset", 32'(rdy[0]), 32'd0);
        tick();
        check("outputs after reset", {26'd0, ctrl[0], ov[0], of[0], ol[0]}, 32'd0);
        rst_n[0] = 1'b1;
        e = cyc;
        issue(0, 5'd2, 6'h20, 6'd0); exp_rep(0, e + 1, 6'h02, 1, 1, 1); tick();
        drive(0, 1'b0, 5'd0, 6'd0, 6'd0);
        tick();

        // 6-bit shamt: SRL 63 = 7x8 + 3x2 + 1.
        e = cyc;
        issue(1, 5'd2, 6'h02, 6'd63);
        exp_rep(1, e + 1, 6'h0F, 7, 1, 0);
        exp_rep(1, e + 8, 6'h0E, 3, 0, 0);
        exp_rep(1, e + 11, 6'h0D, 1, 0, 1);
        tick();
        drive(1, 1'b0, 5'd0, 6'd0, 6'd0);
        repeat (12) tick();

        // Single-cycle multiply, back to back.
        e = cyc;
        issue(2, 5'd2, 6'h19, 6'd0); exp_rep(2, e + 1, 6'h13, 1, 1, 1); tick();
        issue(2, 5'd2, 6'h19, 6'd0); exp_rep(2, e + 2, 6'h13, 1, 1, 1); tick();
        drive(2, 1'b0, 5'd0, 6'd0, 6'd0);
        repeat (3) tick();

        check("scoreboard drained d0", 32'(q0.size()), 32'd0);
        check("scoreboard drained d1", 32'(q1.size()), 32'd0);
        check("scoreboard drained d2", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
